sisc_mem_arbiter: RTL and testbench

//  Shares the single-ported SISC memory between two requesters: port 0 (CPU: ctrl/datapath fetch and LOD/STR)
//  and port 1 (loader/DMA, program load and debug). Each access runs req -> issue -> latency wait -> done pulse.

---
 rtl/sisc_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_sisc_mem_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_mem_arbiter.sv
// sisc_mem_arbiter: shares the single-ported SISC memory between the CPU (port 0)
// and the loader/DMA (port 1). Each access runs IDLE -> ISSUE -> WAIT -> RESP.
// Optional build macro SISC_ARB_CPU_PRIO_EN: fixed CPU priority instead of round robin.
module sisc_mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // WAIT lasts MEM_LAT-1 cycles; the counter runs 0 .. MEM_LAT-2.
  localparam int unsigned LAT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                owner_q;     // 0 = CPU, 1 = DMA
  logic                last_gnt_q;
  logic                acc_we_q;    // owner's we, captured in ISSUE
  logic [LAT_W-1:0]    lat_cnt_q;
  logic [DATA_W-1:0]   cpu_rdata_q, dma_rdata_q;
  logic                pick;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Arbitration decision, only consumed when leaving IDLE.
  always_comb begin
`ifdef SISC_ARB_CPU_PRIO_EN
    pick = ~cpu_req;
`else
    if (cpu_req && dma_req) begin
      pick = ~last_gnt_q;
    end else begin
      pick = ~cpu_req;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cpu_req || dma_req) state_d = StIssue;
      StIssue: state_d = (MEM_LAT == 1) ? StResp : StWait;
      StWait:  if (lat_cnt_q == LAT_LAST) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Owner, latency counter, round-robin history and read-data holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
      acc_we_q    <= 1'b0;
      lat_cnt_q   <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cpu_req || dma_req) owner_q <= pick;
        end
        StIssue: begin
          acc_we_q  <= sel_we;
          lat_cnt_q <= '0;
        end
        StWait: begin
          if (lat_cnt_q != LAT_LAST) lat_cnt_q <= lat_cnt_q + LAT_W'(1);
        end
        StResp: begin
          last_gnt_q <= owner_q;
          if (!acc_we_q) begin
            if (owner_q) dma_rdata_q <= mem_rdata;
            else         cpu_rdata_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; memory request lines are muxed, not registered.
  always_comb begin
    sel_we    = owner_q ? dma_we    : cpu_we;
    sel_addr  = owner_q ? dma_addr  : cpu_addr;
    sel_wdata = owner_q ? dma_wdata : cpu_wdata;
    busy      = (state_q != StIdle);
    mem_en    = (state_q == StIssue);
    mem_we    = mem_en & sel_we;
    mem_addr  = mem_en ? sel_addr  : '0;
    mem_wdata = mem_en ? sel_wdata : '0;
    cpu_gnt   = busy & ~owner_q;
    dma_gnt   = busy &  owner_q;
    cpu_done  = (state_q == StResp) & ~owner_q;
    dma_done  = (state_q == StResp) &  owner_q;
    // Read data is presented in the done cycle, then held by the register.
    cpu_rdata = (cpu_done && !acc_we_q) ? mem_rdata : cpu_rdata_q;
    dma_rdata = (dma_done && !acc_we_q) ? mem_rdata : dma_rdata_q;
  end

endmodule

// File: tb/tb_sisc_mem_arbiter.sv
// Bench for sisc_mem_arbiter: one instance with MEM_LAT=1 and one with MEM_LAT=3,
// each with a small behavioural memory; expected completions go through a queue.
module tb_sisc_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] pat(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {16'hC0DE, a};
  endfunction

  // Instance 1: MEM_LAT = 1
  logic        c1_req = 0, c1_we = 0, d1_req = 0, d1_we = 0;
  logic [15:0] c1_addr = 0, d1_addr = 0;
  logic [31:0] c1_wdata = 0, d1_wdata = 0;
  logic        c1_gnt, c1_done, d1_gnt, d1_done, m1_en, m1_we, busy1;
  logic [31:0] c1_rdata, d1_rdata, m1_wdata, m1_rdata;
  logic [15:0] m1_addr;
  logic [31:0] rd1 = 0, wr1_data = 0;
  logic [15:0] wr1_addr = 0;

  sisc_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .cpu_gnt(c1_gnt), .cpu_done(c1_done), .cpu_rdata(c1_rdata),
    .dma_req(d1_req), .dma_we(d1_we), .dma_addr(d1_addr), .dma_wdata(d1_wdata),
    .dma_gnt(d1_gnt), .dma_done(d1_done), .dma_rdata(d1_rdata),
    .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
    .mem_rdata(m1_rdata), .busy(busy1)
  );

  // Read data is valid only in the cycle after the strobe; zero otherwise.
  always @(posedge clk) begin
    rd1 <= (m1_en && !m1_we) ? pat(m1_addr) : 32'h0;
    if (m1_en && m1_we) begin
      wr1_addr <= m1_addr;
      wr1_data <= m1_wdata;
    end
  end
  assign m1_rdata = rd1;

  // Instance 3: MEM_LAT = 3
  logic        c3_req = 0, c3_we = 0, d3_req = 0, d3_we = 0;
  logic [15:0] c3_addr = 0, d3_addr = 0;
  logic [31:0] c3_wdata = 0, d3_wdata = 0;
  logic        c3_gnt, c3_done, d3_gnt, d3_done, m3_en, m3_we, busy3;
  logic [31:0] c3_rdata, d3_rdata, m3_wdata, m3_rdata;
  logic [15:0] m3_addr;
  logic [31:0] p3_0 = 0, p3_1 = 0, p3_2 = 0;

  sisc_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
    .cpu_gnt(c3_gnt), .cpu_done(c3_done), .cpu_rdata(c3_rdata),
    .dma_req(d3_req), .dma_we(d3_we), .dma_addr(d3_addr), .dma_wdata(d3_wdata),
    .dma_gnt(d3_gnt), .dma_done(d3_done), .dma_rdata(d3_rdata),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata), .busy(busy3)
  );

  always @(posedge clk) begin
    p3_0 <= (m3_en && !m3_we) ? pat(m3_addr) : 32'h0;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign m3_rdata = p3_2;

  task automatic test_reset;
    rst = 1'b1;
    c1_req = 1; d1_req = 1; c3_req = 1; d3_req = 1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({c1_gnt, d1_gnt, c1_done, d1_done, m1_en, m1_we, busy1} !== 7'b0) begin
        failures++;
        $display("FAIL reset_ctl1: got %b want 0000000",
                 {c1_gnt, d1_gnt, c1_done, d1_done, m1_en, m1_we, busy1});
      end
      checks++;
      if ({c3_gnt, d3_gnt, c3_done, d3_done, m3_en, busy3} !== 6'b0) begin
        failures++;
        $display("FAIL reset_ctl3: got %b want 000000",
                 {c3_gnt, d3_gnt, c3_done, d3_done, m3_en, busy3});
      end
    end
    checks++;
    if ({c1_rdata, d1_rdata, c3_rdata} !== 96'h0) begin
      failures++;
      $display("FAIL reset_rdata: got %h %h %h want 0", c1_rdata, d1_rdata, c3_rdata);
    end
    c1_req = 0; d1_req = 0; c3_req = 0; d3_req = 0;
    rst = 1'b0;
  endtask

  task automatic test_cpu_read;
    int   done_cyc = 0;
    exp_t e;
    @(negedge clk);
    c1_req = 1; c1_we = 0; c1_addr = 16'h0010;
    exp_q.push_back('{port: 1'b0, rdata: 32'hDEADBEEF});
    for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 1) begin
        checks++;
        if ({m1_en, m1_we, c1_gnt, d1_gnt, m1_addr} !== {4'b1010, 16'h0010}) begin
          failures++;
          $display("FAIL cpu_read_issue: got en/we/cg/dg=%b addr=%h want 1010 0010",
                   {m1_en, m1_we, c1_gnt, d1_gnt}, m1_addr);
        end
      end
      if (c1_done || d1_done) begin
        done_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL cpu_read_sb: got unexpected done, want none");
        end else begin
          e = exp_q.pop_front();
          if ({d1_done, (d1_done ? d1_rdata : c1_rdata)} !== {e.port, e.rdata}) begin
            failures++;
            $display("FAIL cpu_read_sb: got port=%0d data=%h want port=%0d data=%h",
                     d1_done, d1_done ? d1_rdata : c1_rdata, e.port, e.rdata);
          end
        end
        c1_req = 0;
      end
    end
    checks++;
    if (done_cyc != 2) begin
      failures++;
      $display("FAIL cpu_read_latency: got %0d want 2", done_cyc);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({c1_done, busy1, c1_rdata} !== {2'b00, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL cpu_read_after: got done=%b busy=%b rdata=%h want 0 0 deadbeef",
               c1_done, busy1, c1_rdata);
    end
  endtask

  task automatic test_dma_write;
    int   done_cyc = 0;
    int   we_cycles = 0;
    int   bad = 0;
    exp_t e;
    @(negedge clk);
    d1_req = 1; d1_we = 1; d1_addr = 16'h0020; d1_wdata = 32'h12345678;
    exp_q.push_back('{port: 1'b1, rdata: 32'h0});
    for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (m1_we) we_cycles++;
      if ((m1_we && !m1_en) || c1_gnt || c1_done) bad++;
      if (c1_done || d1_done) begin
        done_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL dma_write_sb: got unexpected done, want none");
        end else begin
          e = exp_q.pop_front();
          if ({d1_done, (d1_done ? d1_rdata : c1_rdata)} !== {e.port, e.rdata}) begin
            failures++;
            $display("FAIL dma_write_sb: got port=%0d data=%h want port=%0d data=%h",
                     d1_done, d1_done ? d1_rdata : c1_rdata, e.port, e.rdata);
          end
        end
        d1_req = 0;
      end
    end
    checks++;
    if ({done_cyc, we_cycles, bad} !== {32'd2, 32'd1, 32'd0}) begin
      failures++;
      $display("FAIL dma_write_timing: got done=%0d we_cycles=%0d bad=%0d want 2 1 0",
               done_cyc, we_cycles, bad);
    end
    checks++;
    if ({wr1_addr, wr1_data} !== {16'h0020, 32'h12345678}) begin
      failures++;
      $display("FAIL dma_write_mem: got %h=%h want 0020=12345678", wr1_addr, wr1_data);
    end
    d1_we = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({d1_done, busy1, d1_rdata} !== {2'b00, 32'h0}) begin
      failures++;
      $display("FAIL dma_write_after: got done=%b busy=%b rdata=%h want 0 0 0",
               d1_done, busy1, d1_rdata);
    end
  endtask

  task automatic test_round_robin;
    int   ndone = 0;
    int   prev = 0;
    int   both = 0;
    exp_t e;
    @(negedge clk);
    c1_addr = 16'h0030; d1_addr = 16'h0040; c1_we = 0; d1_we = 0;
    c1_req = 1; d1_req = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef SISC_ARB_CPU_PRIO_EN
      exp_q.push_back('{port: 1'b0, rdata: 32'hC0DE0030});
`else
      if (i % 2 == 0) exp_q.push_back('{port: 1'b0, rdata: 32'hC0DE0030});
      else            exp_q.push_back('{port: 1'b1, rdata: 32'hC0DE0040});
`endif
    end
    for (int cyc = 1; cyc <= 40 && ndone < 4; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if ((c1_gnt && d1_gnt) || (m1_en && !(c1_gnt || d1_gnt))) both++;
      if (c1_done || d1_done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rr_sb: got unexpected done, want none");
        end else begin
          e = exp_q.pop_front();
          if ({d1_done, (d1_done ? d1_rdata : c1_rdata)} !== {e.port, e.rdata}) begin
            failures++;
            $display("FAIL rr_sb%0d: got port=%0d data=%h want port=%0d data=%h", ndone,
                     d1_done, d1_done ? d1_rdata : c1_rdata, e.port, e.rdata);
          end
        end
        if (ndone > 0) begin
          checks++;
          if (cyc - prev != 3) begin
            failures++;
            $display("FAIL rr_spacing: got %0d cycles want 3", cyc - prev);
          end
        end
        prev = cyc;
        ndone++;
        if (ndone == 4) begin
          c1_req = 0; d1_req = 0;
        end
      end
    end
    checks++;
    if (ndone != 4 || both != 0) begin
      failures++;
      $display("FAIL rr_count: got done=%0d overlap=%0d want 4 0", ndone, both);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_lat3;
    int   done_cyc = 0;
    exp_t e;
    @(negedge clk);
    c3_req = 1; c3_we = 0; c3_addr = 16'h0050;
    exp_q.push_back('{port: 1'b0, rdata: 32'hC0DE0050});
    for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 2) begin
        checks++;
        if ({m3_en, busy3, c3_gnt, c3_done} !== 4'b0110) begin
          failures++;
          $display("FAIL lat3_wait: got en/busy/gnt/done=%b want 0110",
                   {m3_en, busy3, c3_gnt, c3_done});
        end
        c3_req = 0;
      end
      if (c3_done || d3_done) begin
        done_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL lat3_sb: got unexpected done, want none");
        end else begin
          e = exp_q.pop_front();
          if ({d3_done, (d3_done ? d3_rdata : c3_rdata)} !== {e.port, e.rdata}) begin
            failures++;
            $display("FAIL lat3_sb: got port=%0d data=%h want port=%0d data=%h",
                     d3_done, d3_done ? d3_rdata : c3_rdata, e.port, e.rdata);
          end
        end
      end
    end
    checks++;
    if (done_cyc != 4) begin
      failures++;
      $display("FAIL lat3_latency: got %0d want 4", done_cyc);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({c3_done, busy3, m3_en} !== 3'b000) begin
      failures++;
      $display("FAIL lat3_after: got done/busy/en=%b want 000", {c3_done, busy3, m3_en});
    end
  endtask

  task automatic test_reset_in_wait;
    int   done_cyc = 0;
    int   stray = 0;
    exp_t e;
    @(negedge clk);
    c3_req = 1; c3_we = 0; c3_addr = 16'h0060;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({m3_en, m3_we, c3_gnt, busy3, c3_done} !== 5'b0) begin
      failures++;
      $display("FAIL rst_wait_abort: got en/we/gnt/busy/done=%b want 00000",
               {m3_en, m3_we, c3_gnt, busy3, c3_done});
    end
    c3_req = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (c3_done || d3_done || busy3) stray++;
    end
    checks++;
    if (stray != 0 || c3_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_wait_quiet: got stray=%0d rdata=%h want 0 0", stray, c3_rdata);
    end
    c3_req = 1; c3_addr = 16'h0010;
    exp_q.push_back('{port: 1'b0, rdata: 32'hDEADBEEF});
    for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (c3_done || d3_done) begin
        done_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rst_wait_sb: got unexpected done, want none");
        end else begin
          e = exp_q.pop_front();
          if ({d3_done, (d3_done ? d3_rdata : c3_rdata)} !== {e.port, e.rdata}) begin
            failures++;
            $display("FAIL rst_wait_sb: got port=%0d data=%h want port=%0d data=%h",
                     d3_done, d3_done ? d3_rdata : c3_rdata, e.port, e.rdata);
          end
        end
        c3_req = 0;
      end
    end
    checks++;
    if (done_cyc != 4) begin
      failures++;
      $display("FAIL rst_wait_latency: got %0d want 4", done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_round_robin();
    test_lat3();
    test_reset_in_wait();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
